// File: rtl/not_not_pkg.sv
// not_not_pkg: shared FSM states, logic modes, force_sel field offsets and LFSR tap table for the Not-Not round engine
package not_not_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_GEN, ST_DRAW, ST_WAIT, ST_CHECK, ST_OVER} state_t;
  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_AND = 2'd1;
  localparam logic [1:0] MODE_OR = 2'd2;
  localparam logic [1:0] MODE_XOR = 2'd3;
  localparam int OFF_COLOUR_B = 0;
  function automatic int off_colour_a(int cw);
    return cw;
  endfunction
  function automatic int off_logic(int cw);
    return 2 * cw;
  endfunction
  function automatic int off_not(int cw);
    return 2 * cw + 2;
  endfunction
  // Maximal-length Fibonacci tap masks for widths 3..16 (bit i set = tap i+1)
  function automatic logic [31:0] lfsr_taps(int w);
    case (w)
      3: return 32'h0006;
      4: return 32'h000C;
      5: return 32'h0014;
      6: return 32'h0030;
      7: return 32'h0060;
      8: return 32'h00B8;
      9: return 32'h0110;
      10: return 32'h0240;
      11: return 32'h0500;
      12: return 32'h0829;
      13: return 32'h100D;
      14: return 32'h2015;
      15: return 32'h6000;
      default: return 32'hD008;
    endcase
  endfunction
endpackage

// File: rtl/not_not_round_engine_lfsr.sv
// lfsr_nbits: Fibonacci LFSR of WIDTH bits seeded with SEED; clk, rst (async high), q = low OUT_W state bits
module lfsr_nbits
  import not_not_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED = 16'hACE1,
  parameter int OUT_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] q
);
  localparam logic [31:0] TAP_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS = TAP_ALL[WIDTH-1:0];
  logic [WIDTH-1:0] r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r <= SEED;
    else r <= {r[WIDTH-2:0], ^(r & TAPS)};
  end
  assign q = r[OUT_W-1:0];
endmodule

// File: rtl/not_not_round_engine.sv
// not_not_round_engine: Not-Not round loop; prompt gen (LFSR/force_sel), draw handshake, timed answer, score/lives, game over
module not_not_round_engine
  import not_not_pkg::*;
#(
  parameter int NUM_COLOURS = 4,
  parameter int LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int SCORE_WIDTH = 8,
  parameter int LIVES = 3,
  localparam int CW = $clog2(NUM_COLOURS),
  localparam int SW = 4 + 2 * CW
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   draw_done,
  input  logic                   answer_valid,
  input  logic [NUM_COLOURS-1:0] answer,
  input  logic                   force_valid,
  input  logic [SW-1:0]          force_sel,
  output logic [1:0]             not_sel,
  output logic [1:0]             logic_sel,
  output logic [CW-1:0]          colour_a,
  output logic [CW-1:0]          colour_b,
  output logic [NUM_COLOURS-1:0] target,
  output logic                   draw_req,
  output logic                   round_active,
  output logic                   round_correct,
  output logic                   round_wrong,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [2:0]             lives,
  output logic                   game_over
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t state, nxt;
  logic [SW-1:0] rnd, sel;
  logic [1:0] f_not, f_logic;
  logic [CW-1:0] f_a, f_b;
  logic [NUM_COLOURS-1:0] mask_a, mask_b, base, tgt_next, ans;
  logic [TW-1:0] timer;
  logic timed_out, ans_onehot, correct;

  lfsr_nbits #(.WIDTH(LFSR_WIDTH), .SEED(SEED), .OUT_W(SW)) u_lfsr (
    .clk(CLOCK_50),
    .rst(reset),
    .q(rnd)
  );

  assign sel = force_valid ? force_sel : rnd;
  assign f_not = sel[off_not(CW)+:2];
  assign f_logic = sel[off_logic(CW)+:2];
  assign f_a = sel[off_colour_a(CW)+:CW];
  assign f_b = sel[OFF_COLOUR_B+:CW];
  assign mask_a = NUM_COLOURS'(1) << f_a;
  assign mask_b = NUM_COLOURS'(1) << f_b;
  assign base = f_logic == MODE_SINGLE ? mask_a :
                f_logic == MODE_AND ? mask_a & mask_b :
                f_logic == MODE_OR ? mask_a | mask_b : mask_a ^ mask_b;
  // An odd number of negations flips the accepted set; an even number cancels out
  assign tgt_next = f_not[0] ? ~base : base;
  assign ans_onehot = ans != '0 && (ans & (ans - 1'b1)) == '0;
  assign correct = timed_out ? target == '0 : ans_onehot && |(ans & target);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE, ST_OVER: nxt = start ? ST_GEN : state;
      ST_GEN: nxt = ST_DRAW;
      ST_DRAW: nxt = draw_done ? ST_WAIT : ST_DRAW;
      ST_WAIT: nxt = answer_valid || timer == '0 ? ST_CHECK : ST_WAIT;
      ST_CHECK: nxt = !correct && lives == 3'd1 ? ST_OVER : ST_GEN;
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    draw_req = state == ST_DRAW;
    round_active = state == ST_WAIT;
    round_correct = state == ST_CHECK && correct;
    round_wrong = state == ST_CHECK && !correct;
    game_over = state == ST_OVER;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      {not_sel, logic_sel, colour_a, colour_b} <= '0;
      target <= '0;
      ans <= '0;
      timed_out <= 1'b0;
      timer <= '0;
      score <= '0;
      lives <= 3'(LIVES);
    end else begin
      case (state)
        ST_IDLE, ST_OVER: if (start) begin
          score <= '0;
          lives <= 3'(LIVES);
        end
        ST_GEN: begin
          {not_sel, logic_sel, colour_a, colour_b} <= {f_not, f_logic, f_a, f_b};
          target <= tgt_next;
        end
        ST_DRAW: if (draw_done) timer <= TW'(TIMEOUT_CYCLES - 1);
        ST_WAIT: begin
          // Captured every cycle; only the value from the exit cycle reaches CHECK, so a late answer beats the timeout
          timer <= timer - 1'b1;
          ans <= answer;
          timed_out <= !answer_valid;
        end
        ST_CHECK: if (correct) score <= score == '1 ? score : score + 1'b1;
                  else lives <= lives - 3'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_not_not_round_engine.sv
// tb_not_not_round_engine: directed self-checking bench for not_not_round_engine (second instance checks 2-bit score saturation)
module tb_not_not_round_engine;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, draw_done = 1'b0, answer_valid = 1'b0, force_valid = 1'b0;
  logic [3:0] answer = '0;
  logic [7:0] force_sel = '0;
  logic [1:0] not_sel, logic_sel, colour_a, colour_b;
  logic [3:0] target;
  logic draw_req, round_active, round_correct, round_wrong, game_over;
  logic [7:0] score;
  logic [2:0] lives;
  logic [1:0] s_not_sel, s_logic_sel, s_colour_a, s_colour_b;
  logic [3:0] s_target;
  logic s_draw_req, s_round_active, s_round_correct, s_round_wrong, s_game_over;
  logic [1:0] s_score;
  logic [2:0] s_lives;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  not_not_round_engine #(.NUM_COLOURS(4), .TIMEOUT_CYCLES(16), .LIVES(2)) dut (
    .CLOCK_50(clk), .reset(rst), .start(start), .draw_done(draw_done), .answer_valid(answer_valid),
    .answer(answer), .force_valid(force_valid), .force_sel(force_sel), .not_sel(not_sel),
    .logic_sel(logic_sel), .colour_a(colour_a), .colour_b(colour_b), .target(target),
    .draw_req(draw_req), .round_active(round_active), .round_correct(round_correct),
    .round_wrong(round_wrong), .score(score), .lives(lives), .game_over(game_over)
  );

  not_not_round_engine #(.NUM_COLOURS(4), .TIMEOUT_CYCLES(16), .LIVES(2), .SCORE_WIDTH(2)) dut_s (
    .CLOCK_50(clk), .reset(rst), .start(start), .draw_done(draw_done), .answer_valid(answer_valid),
    .answer(answer), .force_valid(force_valid), .force_sel(force_sel), .not_sel(s_not_sel),
    .logic_sel(s_logic_sel), .colour_a(s_colour_a), .colour_b(s_colour_b), .target(s_target),
    .draw_req(s_draw_req), .round_active(s_round_active), .round_correct(s_round_correct),
    .round_wrong(s_round_wrong), .score(s_score), .lives(s_lives), .game_over(s_game_over)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gen(input logic [7:0] s);
    force_valid = 1'b1;
    force_sel = s;
    tick();
    force_valid = 1'b0;
  endtask

  task automatic draw();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
  endtask

  task automatic give(input logic [3:0] a);
    answer = a;
    answer_valid = 1'b1;
    tick();
    answer_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_score", score, 0);
    chk("reset_lives", lives, 2);
    chk("reset_draw_req", draw_req, 0);
    chk("reset_game_over", game_over, 0);
    chk("reset_target", target, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("gen_no_draw_yet", draw_req, 0);
    gen(8'b00_10_01_11);
    chk("or_target", target, 4'b1010);
    chk("or_logic_sel", logic_sel, 2);
    chk("or_colours", {colour_a, colour_b}, 4'b01_11);
    chk("draw_req_high", draw_req, 1);
    chk("no_active_in_draw", round_active, 0);
    draw();
    chk("draw_req_dropped", draw_req, 0);
    chk("active_after_draw", round_active, 1);
    give(4'b1000);
    chk("or_correct_pulse", round_correct, 1);
    chk("or_no_wrong", round_wrong, 0);
    chk("check_inactive", round_active, 0);
    chk("score_not_yet", score, 0);
    tick();
    chk("or_score", score, 1);
    chk("correct_one_cycle", round_correct, 0);
    gen(8'b01_01_00_10);
    chk("not_and_target", target, 4'b1111);
    draw();
    give(4'b0001);
    chk("not_and_correct", round_correct, 1);
    tick();
    chk("not_and_score", score, 2);
    gen(8'b10_01_00_10);
    chk("notnot_and_target", target, 4'b0000);
    draw();
    repeat (15) tick();
    chk("timeout_not_early", round_active, 1);
    tick();
    chk("timeout_check_correct", round_correct, 1);
    chk("timeout_check_inactive", round_active, 0);
    tick();
    chk("timeout_score", score, 3);
    chk("timeout_lives", lives, 2);
    gen(8'b00_00_01_00);
    chk("single_target", target, 4'b0010);
    draw();
    repeat (15) tick();
    give(4'b0010);
    chk("simul_correct", round_correct, 1);
    chk("simul_no_wrong", round_wrong, 0);
    tick();
    chk("simul_score", score, 4);
    chk("simul_lives", lives, 2);
    chk("sat_score", s_score, 3);
    gen(8'b11_00_10_00);
    chk("not3_target", target, 4'b1011);
    draw();
    give(4'b0100);
    chk("wrong_pulse", round_wrong, 1);
    chk("wrong_no_correct", round_correct, 0);
    tick();
    chk("wrong_lives", lives, 1);
    chk("wrong_score_kept", score, 4);
    gen(8'b11_00_10_00);
    draw();
    give(4'b0011);
    chk("multibit_wrong", round_wrong, 1);
    tick();
    chk("over_flag", game_over, 1);
    chk("over_lives", lives, 0);
    chk("over_score", score, 4);
    chk("over_draw_req", draw_req, 0);
    give(4'b0001);
    chk("over_ignores_answer", score, 4);
    chk("over_holds", game_over, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_over_low", game_over, 0);
    chk("restart_score", score, 0);
    chk("restart_lives", lives, 2);
    chk("restart_sat_score", s_score, 0);
    gen(8'b00_10_01_11);
    draw();
    give(4'b0010);
    tick();
    chk("pre_reset_score", score, 1);
    gen(8'b00_00_00_00);
    chk("mid_draw_req", draw_req, 1);
    #2 rst = 1'b1;
    #1 chk("async_drop_draw_req", draw_req, 0);
    tick();
    rst = 1'b0;
    chk("midreset_score", score, 0);
    chk("midreset_lives", lives, 2);
    chk("midreset_target", target, 0);
    tick();
    tick();
    chk("idle_stays", draw_req, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("start_latency", draw_req, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
